// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front end for a shared combinational ALU with a tagged valid/ready response.
// Optional ALU_ARB_STATS_EN adds per-port 16-bit accepted-request counters (stat_ops0/stat_ops1).
module alu_req_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic [4:0]       req0_card,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   input  logic [4:0]       req1_card,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_f,
   output logic             rsp_cout,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic [4:0]       alu_card,
   input  logic [WIDTH-1:0] alu_f,
   input  logic             alu_cout,
   input  logic             alu_zero
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]      stat_ops0,
   output logic [15:0]      stat_ops1
`endif
);

   localparam int unsigned CNT_W    = 4;
   localparam logic [4:0]  CARD_MIN = 5'h01;
   localparam logic [4:0]  CARD_MAX = 5'h10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               last_grant;
   logic               grant0;
   logic               grant1;
   logic               accept;
   logic               win_id;
   logic               win_legal;
   logic [WIDTH-1:0]   win_a;
   logic [WIDTH-1:0]   win_b;
   logic               win_cin;
   logic [4:0]         win_card;
   logic               id_q;
   logic [CNT_W-1:0]   cnt;

   // Round-robin: on contention the port that did not win last time is granted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0 = last_grant;
         grant1 = ~last_grant;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; an illegal opcode skips EXEC entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = win_legal ? EXEC : RESP;
            end
         end
         EXEC: begin
            if (cnt == '0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: request handshake and the selected winner's fields.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst && (state == IDLE)) begin
         req0_ready = grant0;
         req1_ready = grant1;
      end
      accept    = req0_ready | req1_ready;
      win_id    = req1_ready;
      win_a     = win_id ? req1_a    : req0_a;
      win_b     = win_id ? req1_b    : req0_b;
      win_cin   = win_id ? req1_cin  : req0_cin;
      win_card  = win_id ? req1_card : req0_card;
      win_legal = (win_card >= CARD_MIN) && (win_card <= CARD_MAX);
   end

   // Operand latch, ALU hold counter and response capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         id_q       <= 1'b0;
         cnt        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_cin    <= 1'b0;
         alu_card   <= 5'd0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_f      <= '0;
         rsp_cout   <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (accept) begin
            last_grant <= win_id;
            id_q       <= win_id;
            if (win_legal) begin
               alu_a    <= win_a;
               alu_b    <= win_b;
               alu_cin  <= win_cin;
               alu_card <= win_card;
               cnt      <= CNT_W'(ALU_LAT - 1);
            end else begin
               rsp_valid <= 1'b1;
               rsp_id    <= win_id;
               rsp_f     <= '1;
               rsp_cout  <= 1'b0;
               rsp_zero  <= 1'b0;
               rsp_err   <= 1'b1;
            end
         end
         if (state == EXEC) begin
            if (cnt == '0) begin
               rsp_valid <= 1'b1;
               rsp_id    <= id_q;
               rsp_f     <= alu_f;
               rsp_cout  <= alu_cout;
               rsp_zero  <= alu_zero;
               rsp_err   <= 1'b0;
               alu_card  <= 5'd0;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
         if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ARB_STATS_EN
   // Per-port accepted-request counters, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ops0 <= 16'd0;
         stat_ops1 <= 16'd0;
      end else begin
         if (req0_ready) begin
            stat_ops0 <= stat_ops0 + 16'd1;
         end
         if (req1_ready) begin
            stat_ops1 <= stat_ops1 + 16'd1;
         end
      end
   end
`endif

endmodule
